// File: rtl/uart_reg_fifo_if.sv
// APB slave-side bus bundle for the UART register/FIFO block.
// The master modport drives the request; the slave modport returns the response.
interface uart_reg_fifo_if #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32
);
   logic [APB_ADDR_WIDTH-1:0] apb_addr_in;
   logic                      apb_psel_in;
   logic                      apb_penable_in;
   logic                      apb_write_in;
   logic [APB_DATA_WIDTH-1:0] apb_wdata_in;
   logic [APB_DATA_WIDTH-1:0] apb_rdata_out;
   logic                      apb_ready_out;
   logic                      apb_slverr_out;

   modport master (
      output apb_addr_in, apb_psel_in, apb_penable_in, apb_write_in, apb_wdata_in,
      input  apb_rdata_out, apb_ready_out, apb_slverr_out
   );

   modport slave (
      input  apb_addr_in, apb_psel_in, apb_penable_in, apb_write_in, apb_wdata_in,
      output apb_rdata_out, apb_ready_out, apb_slverr_out
   );
endinterface

// File: rtl/uart_reg_fifo.sv
// UART register file with TX/RX byte FIFOs behind an APB slave that inserts one wait state.
// Register accesses capture read data on the first ready edge and commit side effects on the second.
module uart_reg_fifo_buf #(
   parameter int DEPTH = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [7:0]                 i_data,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic [7:0]                 o_head,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_pop_ok;
   logic             w_push_ok;

   // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
   assign w_pop_ok   = i_pop & ~i_flush & (r_cnt != {CNT_W{1'b0}});
   assign w_push_ok  = i_push & ~i_flush & ((r_cnt != FULL_CNT) | w_pop_ok);
   assign o_overflow = i_push & ~i_flush & ~w_push_ok;
   assign o_head     = (r_cnt != {CNT_W{1'b0}}) ? r_mem[r_rd_ptr] : 8'h00;
   assign o_count    = r_cnt;

   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
      end else if (i_flush) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_cnt    <= {CNT_W{1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

module uart_reg_fifo #(
   parameter int                        APB_DATA_WIDTH = 32,
   parameter int                        APB_ADDR_WIDTH = 32,
   parameter logic [APB_ADDR_WIDTH-1:0] UART_REG_BASE  = 32'hA030_0000,
   parameter int                        FIFO_DEPTH     = 16
) (
   input  logic              apb_clk_in,
   input  logic              apb_rst_in,
   uart_reg_fifo_if.slave    apb,
   output logic [7:0]        tx_data_out,
   output logic              tx_valid_out,
   input  logic              tx_pop_in,
   input  logic [7:0]        rx_data_in,
   input  logic              rx_push_in,
   output logic [15:0]       dlr_out,
   output logic [1:0]        wls_out,
   output logic              stb_out,
   output logic              pen_out,
   output logic              eps_out,
   output logic              irq_out
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [7:0] OFF_DR  = 8'h00;
   localparam logic [7:0] OFF_IER = 8'h04;
   localparam logic [7:0] OFF_FCR = 8'h08;
   localparam logic [7:0] OFF_LCR = 8'h0C;
   localparam logic [7:0] OFF_LSR = 8'h10;
   localparam logic [7:0] OFF_DLR = 8'h14;
   localparam logic [7:0] OFF_FSR = 8'h18;

   typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_capture;
   logic                      w_commit;
   logic [7:0]                w_off;
   logic                      w_valid;
   logic                      w_wr_commit;
   logic                      w_rd_commit;
   logic [31:0]               w_rd32;
   logic [APB_DATA_WIDTH-1:0] w_rdata;
   logic [7:0]                w_lsr;
   logic [APB_DATA_WIDTH-1:0] r_rdata;
   logic                      r_slverr;
   logic                      r_dr_pop;
   logic [2:0]                r_ier;
   logic [CNT_W-1:0]          r_rxthr;
   logic [4:0]                r_lcr;
   logic [15:0]               r_dlr;
   logic                      r_oe;
   logic                      r_txovf;
   logic                      r_irq;
   logic [7:0]                w_tx_head;
   logic [7:0]                w_rx_head;
   logic [CNT_W-1:0]          w_tx_cnt;
   logic [CNT_W-1:0]          w_rx_cnt;
   logic                      w_tx_push;
   logic                      w_tx_flush;
   logic                      w_rx_pop;
   logic                      w_rx_flush;
   logic                      w_tx_ovf;
   logic                      w_rx_ovf;
   logic                      w_tx_empty;
   logic                      w_rx_empty;
   logic                      w_unused;

   // A threshold of zero would keep the interrupt asserted permanently, so clamp to 1..depth.
   function automatic logic [CNT_W-1:0] clamp_thr(input logic [7:0] v);
      logic [8:0] w_v;
      w_v = {1'b0, v};
      if (w_v == 9'd0) begin
         clamp_thr = CNT_W'(1);
      end else if (w_v > 9'(FIFO_DEPTH)) begin
         clamp_thr = FULL_CNT;
      end else begin
         clamp_thr = CNT_W'(w_v);
      end
   endfunction

   assign w_off       = apb.apb_addr_in[7:0];
   assign w_valid     = (apb.apb_addr_in[APB_ADDR_WIDTH-1:8] == UART_REG_BASE[APB_ADDR_WIDTH-1:8])
                        && (w_off <= OFF_FSR) && (apb.apb_addr_in[1:0] == 2'b00);
   assign w_wr_commit = w_commit & w_valid & apb.apb_write_in;
   assign w_rd_commit = w_commit & w_valid & ~apb.apb_write_in;
   assign w_unused    = ^apb.apb_wdata_in[APB_DATA_WIDTH-1:16];

   always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
      if (apb_rst_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: w_state_nxt = (apb.apb_psel_in & apb.apb_penable_in) ? ST_RESP : ST_IDLE;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_capture = 1'b0;
      w_commit  = 1'b0;
      case (r_state)
         ST_IDLE: w_capture = apb.apb_psel_in & apb.apb_penable_in;
         ST_RESP: w_commit  = apb.apb_psel_in & apb.apb_penable_in;
         default: w_capture = 1'b0;
      endcase
   end

   assign w_tx_push  = w_wr_commit & (w_off == OFF_DR);
   assign w_tx_flush = w_wr_commit & (w_off == OFF_FCR) & apb.apb_wdata_in[0];
   assign w_rx_flush = w_wr_commit & (w_off == OFF_FCR) & apb.apb_wdata_in[1];
   assign w_rx_pop   = w_commit & r_dr_pop;

   uart_reg_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk      (apb_clk_in),
      .i_rst      (apb_rst_in),
      .i_push     (w_tx_push),
      .i_data     (apb.apb_wdata_in[7:0]),
      .i_pop      (tx_pop_in),
      .i_flush    (w_tx_flush),
      .o_head     (w_tx_head),
      .o_count    (w_tx_cnt),
      .o_overflow (w_tx_ovf)
   );

   uart_reg_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk      (apb_clk_in),
      .i_rst      (apb_rst_in),
      .i_push     (rx_push_in),
      .i_data     (rx_data_in),
      .i_pop      (w_rx_pop),
      .i_flush    (w_rx_flush),
      .o_head     (w_rx_head),
      .o_count    (w_rx_cnt),
      .o_overflow (w_rx_ovf)
   );

   assign w_tx_empty = (w_tx_cnt == {CNT_W{1'b0}});
   assign w_rx_empty = (w_rx_cnt == {CNT_W{1'b0}});
   assign w_lsr      = {(w_rx_cnt == FULL_CNT), (w_tx_cnt == FULL_CNT), w_tx_empty,
                        2'b00, r_txovf, r_oe, ~w_rx_empty};

   always_comb begin
      w_rd32 = 32'h0000_0000;
      case (w_off)
         OFF_DR:  w_rd32 = {24'h00_0000, w_rx_head};
         OFF_IER: w_rd32 = {29'h0000_0000, r_ier};
         OFF_FCR: w_rd32 = {16'h0000, 8'(r_rxthr), 8'h00};
         OFF_LCR: w_rd32 = {27'h000_0000, r_lcr};
         OFF_LSR: w_rd32 = {24'h00_0000, w_lsr};
         OFF_DLR: w_rd32 = {16'h0000, r_dlr};
         OFF_FSR: w_rd32 = {7'h00, 9'(w_tx_cnt), 7'h00, 9'(w_rx_cnt)};
         default: w_rd32 = 32'h0000_0000;
      endcase
      w_rdata = {APB_DATA_WIDTH{1'b0}};
      if (w_valid && !apb.apb_write_in) begin
         w_rdata[31:0] = w_rd32;
      end else begin
         w_rdata[31:0] = 32'h0000_0000;
      end
   end

   // Remember whether the captured DR read saw data, so a byte arriving before commit is not lost.
   always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
      if (apb_rst_in) begin
         r_rdata  <= {APB_DATA_WIDTH{1'b0}};
         r_slverr <= 1'b0;
         r_dr_pop <= 1'b0;
      end else if (w_capture) begin
         r_rdata  <= w_rdata;
         r_slverr <= ~w_valid;
         r_dr_pop <= w_valid & ~apb.apb_write_in & (w_off == OFF_DR) & ~w_rx_empty;
      end
   end

   always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
      if (apb_rst_in) begin
         r_ier   <= 3'b000;
         r_rxthr <= CNT_W'(1);
         r_lcr   <= 5'b00000;
         r_dlr   <= 16'h0000;
      end else if (w_wr_commit) begin
         case (w_off)
            OFF_IER: r_ier   <= apb.apb_wdata_in[2:0];
            OFF_FCR: r_rxthr <= clamp_thr(apb.apb_wdata_in[15:8]);
            OFF_LCR: r_lcr   <= apb.apb_wdata_in[4:0];
            OFF_DLR: r_dlr   <= apb.apb_wdata_in[15:0];
            default: r_dlr   <= r_dlr;
         endcase
      end
   end

   // A new overflow in the same cycle as an LSR read wins over the clear.
   always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
      if (apb_rst_in) begin
         r_oe    <= 1'b0;
         r_txovf <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         r_oe    <= w_rx_ovf | (r_oe    & ~(w_rd_commit & (w_off == OFF_LSR)));
         r_txovf <= w_tx_ovf | (r_txovf & ~(w_rd_commit & (w_off == OFF_LSR)));
         r_irq   <= (r_ier[0] & (w_rx_cnt >= r_rxthr)) | (r_ier[1] & w_tx_empty)
                    | (r_ier[2] & (r_oe | r_txovf));
      end
   end

   assign apb.apb_rdata_out  = r_rdata;
   assign apb.apb_slverr_out = r_slverr;
   assign apb.apb_ready_out  = (r_state == ST_RESP);
   assign tx_data_out        = w_tx_head;
   assign tx_valid_out       = ~w_tx_empty;
   assign dlr_out            = r_dlr;
   assign {eps_out, pen_out, stb_out, wls_out} = r_lcr;
   assign irq_out            = r_irq;
endmodule

// File: tb/tb_uart_reg_fifo.sv
// Directed self-checking bench for uart_reg_fifo with hand-computed expected values.
module tb_uart_reg_fifo;
   localparam logic [31:0] B = 32'hA030_0000;

   logic        clk;
   logic        rst;
   logic [7:0]  tx_data_out;
   logic        tx_valid_out;
   logic        tx_pop_in;
   logic [7:0]  rx_data_in;
   logic        rx_push_in;
   logic [15:0] dlr_out;
   logic [1:0]  wls_out;
   logic        stb_out;
   logic        pen_out;
   logic        eps_out;
   logic        irq_out;
   int          n_pass;
   int          n_fail;
   int          n_total;

   uart_reg_fifo_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apb_if ();

   uart_reg_fifo #(
      .APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .UART_REG_BASE(32'hA030_0000), .FIFO_DEPTH(16)
   ) dut (
      .apb_clk_in   (clk),
      .apb_rst_in   (rst),
      .apb          (apb_if.slave),
      .tx_data_out  (tx_data_out),
      .tx_valid_out (tx_valid_out),
      .tx_pop_in    (tx_pop_in),
      .rx_data_in   (rx_data_in),
      .rx_push_in   (rx_push_in),
      .dlr_out      (dlr_out),
      .wls_out      (wls_out),
      .stb_out      (stb_out),
      .pen_out      (pen_out),
      .eps_out      (eps_out),
      .irq_out      (irq_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Optionally pushes an RX byte so that it lands on the same edge as the commit.
   task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic push_at_commit, input logic [7:0] pdata,
                      output logic [31:0] rd, output logic err);
      int n;
      @(negedge clk);
      apb_if.apb_psel_in = 1'b1; apb_if.apb_penable_in = 1'b0;
      apb_if.apb_write_in = wr; apb_if.apb_addr_in = addr; apb_if.apb_wdata_in = wd;
      @(negedge clk);
      apb_if.apb_penable_in = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!apb_if.apb_ready_out && n < 8);
      check("ready_rise", {31'd0, apb_if.apb_ready_out}, 32'd1);
      rd  = apb_if.apb_rdata_out;
      err = apb_if.apb_slverr_out;
      if (push_at_commit) begin
         rx_push_in = 1'b1; rx_data_in = pdata;
      end
      @(posedge clk); #1;
      check("ready_fall", {31'd0, apb_if.apb_ready_out}, 32'd0);
      rx_push_in = 1'b0;
      @(negedge clk);
      apb_if.apb_psel_in = 1'b0; apb_if.apb_penable_in = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      logic        err;
      apb(1'b0, addr, 32'd0, 1'b0, 8'h00, rd, err);
      check({tag, "_data"}, rd, exp);
      check({tag, "_err"}, {31'd0, err}, 32'd0);
   endtask

   task automatic wr_chk(input string tag, input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      logic        err;
      apb(1'b1, addr, wd, 1'b0, 8'h00, rd, err);
      check({tag, "_rdata0"}, rd, 32'd0);
      check({tag, "_err"}, {31'd0, err}, 32'd0);
   endtask

   task automatic bad_chk(input string tag, input logic wr, input logic [31:0] addr);
      logic [31:0] rd;
      logic        err;
      apb(wr, addr, 32'h0000_BEEF, 1'b0, 8'h00, rd, err);
      check({tag, "_rdata0"}, rd, 32'd0);
      check({tag, "_slverr"}, {31'd0, err}, 32'd1);
   endtask

   task automatic push_rx(input logic [7:0] d);
      @(negedge clk); rx_push_in = 1'b1; rx_data_in = d;
      @(negedge clk); rx_push_in = 1'b0;
   endtask

   task automatic pop_tx();
      @(negedge clk); tx_pop_in = 1'b1;
      @(negedge clk); tx_pop_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        err;
      n_pass = 0; n_fail = 0; n_total = 0;
      rst = 1'b1; tx_pop_in = 1'b0; rx_push_in = 1'b0; rx_data_in = 8'h00;
      apb_if.apb_psel_in = 1'b0; apb_if.apb_penable_in = 1'b0; apb_if.apb_write_in = 1'b0;
      apb_if.apb_addr_in = 32'd0; apb_if.apb_wdata_in = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, apb_if.apb_ready_out}, 32'd0);
      check("rst_rdata", apb_if.apb_rdata_out, 32'd0);
      check("rst_slverr", {31'd0, apb_if.apb_slverr_out}, 32'd0);
      check("rst_txvalid", {31'd0, tx_valid_out}, 32'd0);
      check("rst_txdata", {24'd0, tx_data_out}, 32'd0);
      check("rst_lcr", {16'd0, dlr_out}, 32'd0);
      check("rst_line", {27'd0, eps_out, pen_out, stb_out, wls_out}, 32'd0);
      check("rst_irq", {31'd0, irq_out}, 32'd0);
      @(negedge clk); rst = 1'b0;

      rd_chk("lsr_reset", B | 32'h10, 32'h20);
      rd_chk("fcr_reset", B | 32'h08, 32'h100);

      wr_chk("dr_wr11", B, 32'h11);
      wr_chk("dr_wr22", B, 32'h22);
      check("tx_head_11", {24'd0, tx_data_out}, 32'h11);
      rd_chk("fsr_tx2", B | 32'h18, 32'h0002_0000);
      pop_tx();
      check("tx_head_22", {24'd0, tx_data_out}, 32'h22);
      rd_chk("fsr_tx1", B | 32'h18, 32'h0001_0000);
      rd_chk("lsr_tx1", B | 32'h10, 32'h00);

      wr_chk("dlr_wr", B | 32'h14, 32'h0000_1234);
      rd_chk("dlr_rd", B | 32'h14, 32'h1234);
      check("dlr_out", {16'd0, dlr_out}, 32'h1234);
      wr_chk("lcr_wr", B | 32'h0C, 32'h15);
      rd_chk("lcr_rd", B | 32'h0C, 32'h15);
      check("lcr_out", {27'd0, eps_out, pen_out, stb_out, wls_out}, 32'h15);

      bad_chk("base_mismatch", 1'b1, 32'hA031_0014);
      rd_chk("dlr_unchanged", B | 32'h14, 32'h1234);
      bad_chk("off_1c", 1'b0, B | 32'h1C);
      bad_chk("misaligned", 1'b0, B | 32'h15);
      bad_chk("dr_wr_bad_base", 1'b1, 32'hB030_0000);
      rd_chk("fsr_after_bad", B | 32'h18, 32'h0001_0000);

      for (int i = 0; i < 17; i++) push_rx(8'hA0 + 8'(i));
      rd_chk("lsr_ovf", B | 32'h10, 32'h83);
      rd_chk("lsr_ovf_clr", B | 32'h10, 32'h81);
      rd_chk("fsr_rx16", B | 32'h18, 32'h0001_0010);
      apb(1'b0, B, 32'd0, 1'b1, 8'hC5, rd, err);
      check("dr_pop_push_data", rd, 32'hA0);
      rd_chk("fsr_rx16_kept", B | 32'h18, 32'h0001_0010);
      rd_chk("lsr_no_oe", B | 32'h10, 32'h81);
      for (int i = 1; i < 16; i++) rd_chk("dr_order", B, 32'hA0 + i);
      rd_chk("dr_last_new", B, 32'hC5);
      rd_chk("dr_empty", B, 32'h00);
      rd_chk("lsr_rx_empty", B | 32'h10, 32'h00);

      wr_chk("fcr_flush_tx", B | 32'h08, 32'h01);
      check("tx_valid_flushed", {31'd0, tx_valid_out}, 32'd0);
      pop_tx();
      rd_chk("fsr_pop_empty", B | 32'h18, 32'h0);
      rd_chk("lsr_thre", B | 32'h10, 32'h20);

      for (int i = 0; i < 17; i++) wr_chk("dr_fill", B, i);
      rd_chk("lsr_txovf", B | 32'h10, 32'h44);
      rd_chk("lsr_txovf_clr", B | 32'h10, 32'h40);
      rd_chk("fsr_tx16", B | 32'h18, 32'h0010_0000);
      check("tx_head_00", {24'd0, tx_data_out}, 32'h00);
      wr_chk("fcr_flush_both", B | 32'h08, 32'h0403);
      rd_chk("fcr_thr4", B | 32'h08, 32'h0400);
      rd_chk("lsr_both_empty", B | 32'h10, 32'h20);

      wr_chk("ier_wr", B | 32'h04, 32'h1);
      rd_chk("ier_rd", B | 32'h04, 32'h1);
      for (int i = 0; i < 3; i++) push_rx(8'h31 + 8'(i));
      @(negedge clk); rx_push_in = 1'b1; rx_data_in = 8'h34;
      @(posedge clk); #1;
      check("irq_not_yet", {31'd0, irq_out}, 32'd0);
      @(negedge clk); rx_push_in = 1'b0;
      @(posedge clk); #1;
      check("irq_rise", {31'd0, irq_out}, 32'd1);
      rd_chk("dr_irq_pop", B, 32'h31);
      @(posedge clk); #1;
      check("irq_fall", {31'd0, irq_out}, 32'd0);

      wr_chk("fcr_clamp_hi", B | 32'h08, 32'hFF00);
      rd_chk("fcr_thr16", B | 32'h08, 32'h1000);
      wr_chk("dr_wr5a", B, 32'h5A);
      check("tx_head_5a", {24'd0, tx_data_out}, 32'h5A);

      @(negedge clk);
      apb_if.apb_psel_in = 1'b1; apb_if.apb_penable_in = 1'b0; apb_if.apb_write_in = 1'b1;
      apb_if.apb_addr_in = B | 32'h14; apb_if.apb_wdata_in = 32'h0000_AAAA;
      @(negedge clk); apb_if.apb_penable_in = 1'b1;
      @(posedge clk); #1;
      check("abort_ready_hi", {31'd0, apb_if.apb_ready_out}, 32'd1);
      rst = 1'b1; #1;
      check("abort_ready_lo", {31'd0, apb_if.apb_ready_out}, 32'd0);
      @(negedge clk); apb_if.apb_psel_in = 1'b0; apb_if.apb_penable_in = 1'b0;
      @(negedge clk); rst = 1'b0;
      check("abort_no_dlr", {16'd0, dlr_out}, 32'd0);
      check("abort_tx_empty", {31'd0, tx_valid_out}, 32'd0);
      rd_chk("lsr_after_abort", B | 32'h10, 32'h20);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/uart_reg_fifo.md
UART_REG_FIFO -- requirements
Module: uart_reg_fifo

Interface
REQ-001 Parameter APB_DATA_WIDTH, default 32, APB data bus width; must be at least 32.
REQ-002 Parameter APB_ADDR_WIDTH, default 32, APB address bus width.
REQ-003 Parameter UART_REG_BASE, default 32'ha0300000, base address of the register window; bits [7:0] are ignored.
REQ-004 Parameter FIFO_DEPTH, default 16, depth of each of the TX and RX FIFOs; must be a power of 2, range 4..256.
REQ-005 apb_clk_in  input  1  single clock; all logic is rising-edge.
REQ-006 apb_rst_in  input  1  asynchronous, active-high reset.
REQ-007 apb_addr_in  input  APB_ADDR_WIDTH; apb_psel_in  input  1; apb_penable_in  input  1; apb_write_in  input  1; apb_wdata_in  input  APB_DATA_WIDTH: APB request.
REQ-008 apb_rdata_out  output  APB_DATA_WIDTH; apb_ready_out  output  1; apb_slverr_out  output  1: APB response, all registered.
REQ-009 tx_data_out  output  8  TX FIFO head byte; tx_valid_out  output  1  TX FIFO not empty; tx_pop_in  input  1  serializer consumes the head byte.
REQ-010 rx_data_in  input  8  received byte; rx_push_in  input  1  one-cycle push strobe.
REQ-011 dlr_out  output  16  divisor latch; wls_out  output  2, stb_out, pen_out, eps_out  output  1 each: line control fields.
REQ-012 irq_out  output  1  level interrupt, registered.

Function
REQ-013 The register map SHALL be: DR 0x00, IER 0x04, FCR 0x08, LCR 0x0C, LSR 0x10, DLR 0x14, FSR 0x18; the offset is apb_addr_in[7:0].
REQ-014 An access SHALL be valid only if addr[ADDR-1:8]==UART_REG_BASE[ADDR-1:8], the offset is at most 0x18, and addr[1:0]==0.
REQ-015 Ready handshake: at the edge where psel&penable&!ready, apb_ready_out SHALL rise; at the next edge it SHALL fall, giving exactly one wait state.
REQ-016 apb_rdata_out and apb_slverr_out SHALL be loaded at the same edge ready rises; apb_rdata_out SHALL be 0 for writes and for invalid accesses.
REQ-017 Register side effects SHALL commit at the edge where psel&penable&ready is sampled; an invalid access SHALL set slverr=1 and have no side effect.
REQ-018 A DR write SHALL push wdata[7:0] into the TX FIFO; a write to a full TX FIFO SHALL be dropped and SHALL set the sticky bit TXOVF.
REQ-019 A DR read SHALL return the RX head byte in [7:0] and pop it; a read of an empty RX FIFO SHALL return 0 with no pop.
REQ-020 IER [2:0] SHALL be read/write, with bit0 RX-threshold enable, bit1 TX-empty enable, bit2 error enable.
REQ-021 FCR write: bit0 SHALL flush TX, bit1 SHALL flush RX (self-clearing, read as 0); bits[15:8] are RXTHR, clamped to 1..FIFO_DEPTH, reset value 1.
REQ-022 LCR [4:0] SHALL map to {eps, pen, stb, wls[1:0]}, read/write.
REQ-023 LSR (read-only) SHALL be: bit0 DR=rx not empty, bit1 OE, bit2 TXOVF, bit5 THRE=tx empty, bit6 TXFULL, bit7 RXFULL.
REQ-024 Reading LSR SHALL clear OE and TXOVF after the returned value is captured.
REQ-025 DLR [15:0] SHALL be read/write.
REQ-026 FSR (read-only) SHALL return rx_count in [8:0] and tx_count in [24:16].
REQ-027 An rx_push_in while RX is full and no pop occurs in the same cycle SHALL drop the byte and set OE.
REQ-028 A push and a pop on the same FIFO in the same cycle SHALL both take effect, leaving the count unchanged with no overflow, including when the FIFO is full; when the FIFO is empty, only the push SHALL occur.
REQ-029 tx_pop_in while the TX FIFO is empty SHALL be ignored.
REQ-030 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo the depth; counts SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-031 A flush SHALL zero the pointers and count in the cycle it commits; a push or pop in that same cycle SHALL be discarded.
REQ-032 irq_out SHALL be registered as (IER0 & rx_count>=RXTHR) | (IER1 & tx empty) | (IER2 & (OE|TXOVF)).

Reset
REQ-033 While apb_rst_in is high, all outputs SHALL be 0, except that RXTHR is 1 and both FIFOs are empty.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer immediately; no side effect commits, and the next transfer starts cleanly.

Verification
REQ-035 Reset, then read LSR -> rdata=0x20, slverr=0, ready high for exactly one cycle.
REQ-036 Write DR 0x11, 0x22, then pulse tx_pop_in once -> tx_data_out=0x22, FSR tx_count=1.
REQ-037 Push FIFO_DEPTH+1 RX bytes -> LSR=0x83 (RXFULL, OE, DR); a second LSR read returns 0x81; DR reads return the first FIFO_DEPTH bytes in order.
REQ-038 RX full, rx_push_in coincident with a DR-read commit -> no OE, count stays FIFO_DEPTH, new byte is last.
REQ-039 IER=1, RXTHR=4, push 4 bytes -> irq_out rises one cycle after the 4th push; one DR read drops it.
REQ-040 Access offset 0x1C or base mismatch -> slverr=1, rdata=0, no register change.
